// File: rtl/ldpc_gf8_pkg.sv
// GF(8) types and arithmetic shared by the non-binary LDPC decoder.
// Field is built on x^3+x+1 with alpha = 3'b010.
package ldpc_gf8_pkg;

    typedef logic [2:0] gf8_t;

    typedef enum logic [1:0] {
        CN_IDLE,
        CN_COLLECT,
        CN_EMIT
    } cn_state_t;

    localparam logic [3:0] GF8_PRIM_POLY = 4'b1011;

    function automatic gf8_t gf8_mul(gf8_t a, gf8_t b);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) p = p ^ (5'(a) << i);
        end
        for (int i = 4; i >= 3; i--) begin
            if (p[i]) p = p ^ (5'(GF8_PRIM_POLY) << (i - 3));
        end
        return p[2:0];
    endfunction

    // Zero has no inverse; it maps to 1 so an illegal h behaves as h = 1.
    function automatic gf8_t gf8_inv(gf8_t a);
        gf8_t r;
        unique case (a)
            3'd2:    r = 3'd5;
            3'd3:    r = 3'd6;
            3'd4:    r = 3'd7;
            3'd5:    r = 3'd2;
            3'd6:    r = 3'd3;
            3'd7:    r = 3'd4;
            default: r = 3'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cn_gf8_mul.sv
// Combinational GF(8) multiplier.
// Thin wrapper so the field product appears as a reusable cell.
module gf8_mul (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [2:0] p
);

    assign p = ldpc_gf8_pkg::gf8_mul(a, b);

endmodule

// File: rtl/cn_gf8.sv
// GF(8) check node: serial v2c collect, then extrinsic c2v emit.
// Define CN_FAIL_CNT_EN to build the saturating unsatisfied-check counter.
module cn_gf8
    import ldpc_gf8_pkg::*;
#(
    parameter int DC   = 6,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      v2c,
    input  logic [2:0]      h_coef,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      c2v,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            chk_ok,
    output logic            chk_valid,
    output logic [15:0]     fail_cnt
);

    localparam int AW = (DC > 2) ? $clog2(DC) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(DC - 1);

    cn_state_t       state;
    logic [IDXW-1:0] cnt;
    gf8_t            s;
    gf8_t            p_buf [DC];
    gf8_t            h_buf [DC];

    gf8_t            h_in;
    gf8_t            p_in;
    gf8_t            s_sel;
    gf8_t            o_scale;
    gf8_t            o_sum;
    gf8_t            c2v_nxt;
    logic [IDXW-1:0] sel;
    logic            accept;
    logic            last_in;
    gf8_t            s_fin;

    assign h_in    = (h_coef == 3'd0) ? 3'd1 : h_coef;
    assign accept  = in_valid & in_ready;
    assign last_in = accept && (state == CN_COLLECT) && (cnt == LAST);
    assign s_fin   = s ^ p_in;

    gf8_mul u_mul_in (
        .a (h_in),
        .b (v2c),
        .p (p_in)
    );

    // Look one edge ahead so the registered c2v is ready on the next cycle.
    assign sel     = (state == CN_EMIT && cnt != LAST) ? cnt + 1'b1 : '0;
    assign s_sel   = (state == CN_EMIT) ? s : s_fin;
    assign o_scale = gf8_inv(h_buf[sel[AW-1:0]]);
    assign o_sum   = s_sel ^ p_buf[sel[AW-1:0]];

    gf8_mul u_mul_out (
        .a (o_scale),
        .b (o_sum),
        .p (c2v_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CN_IDLE;
            cnt       <= '0;
            s         <= '0;
            for (int i = 0; i < DC; i++) begin
                p_buf[i] <= '0;
                h_buf[i] <= '0;
            end
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            c2v       <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            chk_ok    <= 1'b0;
            chk_valid <= 1'b0;
        end else begin
            chk_valid <= 1'b0;
            unique case (state)
                CN_IDLE: begin
                    if (accept) begin
                        p_buf[0] <= p_in;
                        h_buf[0] <= h_in;
                        s        <= p_in;
                        cnt      <= IDXW'(1);
                        state    <= CN_COLLECT;
                    end
                end
                CN_COLLECT: begin
                    if (accept) begin
                        p_buf[cnt[AW-1:0]] <= p_in;
                        h_buf[cnt[AW-1:0]] <= h_in;
                        s                  <= s_fin;
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            state     <= CN_EMIT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            c2v       <= c2v_nxt;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                            chk_valid <= 1'b1;
                            chk_ok    <= (s_fin == 3'd0);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CN_EMIT: begin
                    if (out_ready) begin
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            s         <= '0;
                            state     <= CN_IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            c2v       <= '0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            out_idx  <= cnt + 1'b1;
                            out_last <= (cnt + 1'b1 == LAST);
                            c2v      <= c2v_nxt;
                        end
                    end
                end
                default: state <= CN_IDLE;
            endcase
        end
    end

`ifdef CN_FAIL_CNT_EN
    logic [15:0] fail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= '0;
        end else if (last_in && s_fin != 3'd0 && fail_q != 16'hFFFF) begin
            fail_q <= fail_q + 16'd1;
        end
    end

    assign fail_cnt = fail_q;
`else
    assign fail_cnt = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            assert (h_coef != 3'd0)
            else $error("cn_gf8: zero h_coef accepted");
        end
    end
`endif

endmodule
